// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU opcodes, word width and the multiplier state encoding.
package mips_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_AND = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;
   localparam logic [1:0] ALU_SUB = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } mult_state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// Shift-and-add multiplier controller that borrows the shared ALU for its additions.
// Optional signed MULT support is compiled in with SIGNED_MULT_EN.
module alu_mult_seq
   import mips_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SIGNED_MULT_EN
   input  logic             is_signed,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] alu_r1,
   output logic [WIDTH-1:0] alu_r2,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result
);

   mult_state_t          state;
   logic [CNT_W-1:0]     counter;
   logic [WIDTH-1:0]     mcand;
   logic                 carry;
   logic [2*WIDTH-1:0]   stepProd;
   logic [2*WIDTH-1:0]   finalProd;
   logic [WIDTH-1:0]     opA;
   logic [WIDTH-1:0]     opB;
   logic                 lastStep;

`ifdef SIGNED_MULT_EN
   logic                 neg;
`endif

   // The ALU is only ours during COMPUTE; otherwise it sees quiet zero operands.
   always_comb begin
      alu_op = ALU_ADD;
      alu_r1 = '0;
      alu_r2 = '0;
      if (state == COMPUTE) begin
         alu_r1 = hi;
         alu_r2 = mcand;
      end
   end

   // One shift-and-add iteration; the ALU drops its carry-out, so we recover it
   // from the unsigned wrap-around of the sum.
   always_comb begin
      carry    = (alu_result < hi);
      stepProd = {1'b0, hi, lo[WIDTH-1:1]};
      if (lo[0]) begin
         stepProd = {carry, alu_result, lo[WIDTH-1:1]};
      end
   end

   assign lastStep = (counter == CNT_W'(WIDTH - 1));

`ifdef SIGNED_MULT_EN
   // Operands become magnitudes; the sign is reapplied on the final iteration.
   always_comb begin
      opA = a;
      opB = b;
      if (is_signed) begin
         opA = a[WIDTH-1] ? -a : a;
         opB = b[WIDTH-1] ? -b : b;
      end
      finalProd = neg ? -stepProd : stepProd;
   end
`else
   always_comb begin
      opA       = a;
      opB       = b;
      finalProd = stepProd;
   end
`endif

   // Controller FSM with registered busy/done; lo doubles as the multiplier shift register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         counter <= '0;
         mcand   <= '0;
`ifdef SIGNED_MULT_EN
         neg     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  mcand   <= opA;
                  lo      <= opB;
                  hi      <= '0;
                  counter <= '0;
                  busy    <= 1'b1;
                  state   <= COMPUTE;
`ifdef SIGNED_MULT_EN
                  neg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
               end
            end
            COMPUTE: begin
               busy    <= 1'b1;
               counter <= counter + 1'b1;
               if (lastStep) begin
                  {hi, lo} <= finalProd;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  {hi, lo} <= stepProd;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
